// File: rtl/scpu_mem_pkg.sv
// Shared constants for the SCPU data-memory front end: default widths, arbitration
// modes and the MEMORY write-enable encoding.
package scpu_mem_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ADDR_W = 13;

   localparam int unsigned ARB_FIXED = 0;
   localparam int unsigned ARB_RR    = 1;

   // MEMORY write enable is active-low
   typedef enum logic {
      WEN_WRITE = 1'b0,
      WEN_IDLE  = 1'b1
   } wen_e;

endpackage

// File: rtl/scpu_mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: packed per-channel commands in, one-hot
// grant and read-valid strobes plus shared read data out.
interface scpu_mem_arbiter_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned DATA_W = scpu_mem_pkg::DEF_DATA_W,
   parameter int unsigned ADDR_W = scpu_mem_pkg::DEF_ADDR_W
) ();

   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        we;
   logic [NUM_CH*ADDR_W-1:0] addr;
   logic [NUM_CH*DATA_W-1:0] wdata;
   logic [NUM_CH-1:0]        gnt;
   logic [NUM_CH-1:0]        rvalid;
   logic [DATA_W-1:0]        rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot arbiter: fixed priority (channel 0 first) or round-robin starting after the
// last winner. Grant is combinational and forced low during reset.
module rr_arbiter
   import scpu_mem_pkg::*;
#(
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned ARB_MODE = ARB_RR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] gnt
);

   // mask_q marks the channels at or above the current round-robin start point
   logic [NUM_CH-1:0] mask_q;
   logic [NUM_CH-1:0] mask_d;
   logic [NUM_CH-1:0] mask_eff;
   logic [NUM_CH-1:0] req_hi;
   logic [NUM_CH-1:0] cand;
   logic [NUM_CH-1:0] gnt_shl;

   always_comb begin
      mask_eff = (ARB_MODE == ARB_RR) ? mask_q : '1;
      req_hi   = req & mask_eff;
      // nothing at/above the start point: wrap around to the lowest requester
      cand     = (|req_hi) ? req_hi : req;
      gnt      = rst ? '0 : (cand & (~cand + NUM_CH'(1)));
      gnt_shl  = gnt << 1;
      // channels strictly above the winner; all-zero after the top channel wins
      mask_d   = (|gnt) ? ~(gnt_shl - NUM_CH'(1)) : mask_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '1;
      end else begin
         mask_q <= mask_d;
      end
   end

endmodule

// File: rtl/scpu_mem_arbiter.sv
// Multi-channel front end for the single-port SCPU data memory: arbitrates one access
// per cycle, registers the memory command and returns read data via a tag pipeline.
module scpu_mem_arbiter
   import scpu_mem_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned ARB_MODE = ARB_RR
) (
   input  logic               clk,
   input  logic               rst,
   scpu_mem_arbiter_if.slave  bus,
   output logic               WEN,
   output logic [ADDR_W-1:0]  ADDR,
   output logic [DATA_W-1:0]  MEM_in,
   input  logic [DATA_W-1:0]  MEM_out
);

   logic [NUM_CH-1:0] gnt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // tag_q[i] holds the one-hot issuing channel of a read i+1 cycles after its grant
   logic [NUM_CH-1:0] tag_q [RD_LAT+1];

   rr_arbiter #(
      .NUM_CH   (NUM_CH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk (clk),
      .rst (rst),
      .req (bus.req),
      .gnt (gnt)
   );

   // One-hot AND-OR select of the winning channel's command
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         if (gnt[ch]) begin
            sel_we    = sel_we | bus.we[ch];
            sel_addr  = sel_addr | bus.addr[ch*ADDR_W +: ADDR_W];
            sel_wdata = sel_wdata | bus.wdata[ch*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WEN    <= WEN_IDLE;
         ADDR   <= '0;
         MEM_in <= '0;
      end else if (|gnt) begin
         WEN    <= sel_we ? WEN_WRITE : WEN_IDLE;
         ADDR   <= sel_addr;
         MEM_in <= sel_wdata;
      end else begin
         WEN    <= WEN_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i <= RD_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= gnt & ~bus.we;
         for (int unsigned i = 1; i <= RD_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign bus.gnt    = gnt;
   assign bus.rvalid = tag_q[RD_LAT];
   assign bus.rdata  = MEM_out;

endmodule
